itran_4x4: RTL
==============

// Module: itran_4x4
// PURPOSE
//  Inverse 4x4 H.264 core integer transform. This is the decoder and reconstruction-path counterpart of the forward 4x4 transform.
//  Takes 16 dequantised coefficients and produces 16 reconstructed residuals, computed as (x+32)>>>6.
//  Sits between dequant and prediction-add. Valid/ready handshake on both sides.
//  Iterative datapath: one row per cycle for 4 cycles, then one column per cycle for 4 cycles.
// PARAMETERS
//  IN_WIDTH    16  signed width of each input coefficient
//  OUT_WIDTH   16  signed width of each output residual; result saturates to this width
//  INT_WIDTH   IN_WIDTH+4  signed width of the row-pass buffer and the column-pass arithmetic
// PORTS
//  clk        in   1                   rising-edge clock
//  reset      in   1                   asynchronous, active-high reset
//  in_valid   in   1                   coeffs valid
//  in_ready   out  1                   block can accept a new coefficient block
//  coeffs     in   IN_WIDTH x[15:0]    signed coefficients, row-major, index 4*row+col
//  out_valid  out  1                   residuals valid
//  out_ready  in   1                   downstream accepts residuals
//  residuals  out  OUT_WIDTH x[15:0]   signed residuals, row-major, registered
//  sat        out  1                   1 if any of the 16 residuals was clipped in this block
//  busy       out  1                   1 in every state other than IDLE
// BEHAVIOUR
//  Reset (asynchronous):
//   state=IDLE, out_valid=0, residuals=0, sat=0, internal buffers=0.
//   in_ready=0 while reset is asserted.
//  FSM states: IDLE -> ROW -> COL -> DONE -> IDLE.
//  IDLE: in_ready=1. On an edge with in_valid&in_ready: latch coeffs, idx=0, go to ROW.
//  1-D kernel, applied to a[0..3]:
//   e=a0+a2, f=a0-a2, g=(a1>>>1)-a3, h=a1+(a3>>>1)
//   y0=e+h, y1=f+g, y2=f-g, y3=e-h
//   >>> is an arithmetic shift; all operands are sign-extended to INT_WIDTH.
//  ROW (4 cycles, idx 0..3): apply the kernel to row idx of the latched coeffs and write buf[idx][0..3].
//   After idx=3, set idx=0 and go to COL.
//  COL (4 cycles, idx 0..3): apply the kernel to column idx, a_k = buf[k][idx].
//   Output: residuals[4k+idx] = sat((y_k+32)>>>6).
//   sat() clips to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
//   sat is cleared at the ROW->COL transition and ORs in any clip from each column.
//   After idx=3, go to DONE.
//  DONE: out_valid=1. residuals and sat are held stable until out_valid&out_ready.
//   On that edge: out_valid=0, go to IDLE. residuals keep their last value.
//  Latency: out_valid rises exactly 8 clk edges after the input-accept edge.
//  Minimum initiation interval is 10 cycles: accept, 8 compute cycles, output handshake.
//  No input/output overlap: in_ready=0 in ROW, COL and DONE. in_valid in those states is ignored.
//  Coefficient changes on coeffs after the accept edge have no effect on the current block.
//  out_ready in IDLE, ROW or COL is ignored.
//  Reset mid-operation: abort immediately and discard the block. No out_valid is produced for it.
//  Width: with IN_WIDTH input, the two passes grow magnitude by at most 4 bits, so INT_WIDTH never overflows.
//   Saturation happens only at the final narrowing to OUT_WIDTH.
// TESTING
//  T1 All-zero coeffs -> out_valid 8 edges after accept; all residuals=0, sat=0.
//  T2 DC block: coeffs[0]=64, others 0 -> all 16 residuals=1.
//     coeffs[0]=-64 -> all 16 residuals=-1.
//  T3 AC block: coeffs[1]=64, others 0 -> each row = [1,1,0,-1]
//     (residuals[4r+0..3]); sat=0.
//  T4 Backpressure: hold out_ready=0 for 5 cycles in DONE -> residuals stable, in_ready=0.
//     Then pulse out_ready=1 -> IDLE next edge. A back-to-back second block is accepted one cycle later.
//  T5 Saturation: OUT_WIDTH=8, coeffs[0]=32767 -> all residuals=127, sat=1.
//     coeffs[0]=-32768 -> all residuals=-128, sat=1.
//  T6 Reset asserted during COL (idx=2) -> out_valid stays 0, residuals=0.
//     Next block is accepted normally and yields correct T2 values.

Source files
------------

// File: rtl/itran_4x4.sv
// Inverse 4x4 H.264 core integer transform: row pass then column pass, one vector per cycle,
// rounded by (x+32)>>>6 and saturated to OUT_WIDTH. Valid/ready on input and output.
module itran_4x4 #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned INT_WIDTH = IN_WIDTH + 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [15:0][IN_WIDTH-1:0]      coeffs,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [15:0][OUT_WIDTH-1:0]     residuals,
  output logic                           sat,
  output logic                           busy
);

  typedef enum logic [1:0] {StIdle, StRow, StCol, StDone} state_e;
  typedef logic signed [INT_WIDTH-1:0] int_t;

  localparam int_t SatMax = int_t'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam int_t SatMin = int_t'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  function automatic logic [3:0][INT_WIDTH-1:0] kernel(input logic [3:0][INT_WIDTH-1:0] a);
    int_t e, f, g, h;
    e = $signed(a[0]) + $signed(a[2]);
    f = $signed(a[0]) - $signed(a[2]);
    g = ($signed(a[1]) >>> 1) - $signed(a[3]);
    h = $signed(a[1]) + ($signed(a[3]) >>> 1);
    kernel[0] = e + h;
    kernel[1] = f + g;
    kernel[2] = f - g;
    kernel[3] = e - h;
  endfunction

  state_e                            state_q, state_d;
  logic [1:0]                        idx_q;
  logic [15:0][IN_WIDTH-1:0]         coef_q;
  logic [3:0][3:0][INT_WIDTH-1:0]    buf_q;
  logic [15:0][OUT_WIDTH-1:0]        residuals_q;
  logic                              sat_q;

  logic [3:0][INT_WIDTH-1:0]         row_a, row_y, col_a, col_y;
  logic [3:0][OUT_WIDTH-1:0]         col_res;
  logic                              col_clip;

  always_comb begin
    row_a = '0;
    col_a = '0;
    for (int k = 0; k < 4; k++) begin
      row_a[k] = INT_WIDTH'($signed(coef_q[{idx_q, 2'(k)}]));
      col_a[k] = buf_q[k][idx_q];
    end
  end

  assign row_y = kernel(row_a);
  assign col_y = kernel(col_a);

  // Round, then clip only at the final narrowing; INT_WIDTH headroom covers both passes.
  always_comb begin
    int_t r;
    r        = '0;
    col_res  = '0;
    col_clip = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r = ($signed(col_y[k]) + int_t'(32)) >>> 6;
      if (r > SatMax) begin
        col_res[k] = SatMax[OUT_WIDTH-1:0];
        col_clip   = 1'b1;
      end else if (r < SatMin) begin
        col_res[k] = SatMin[OUT_WIDTH-1:0];
        col_clip   = 1'b1;
      end else begin
        col_res[k] = r[OUT_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid)       state_d = StRow;
      StRow:  if (idx_q == 2'd3)  state_d = StCol;
      StCol:  if (idx_q == 2'd3)  state_d = StDone;
      StDone: if (out_ready)      state_d = StIdle;
      default:                    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      coef_q      <= '0;
      buf_q       <= '0;
      residuals_q <= '0;
      sat_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            coef_q <= coeffs;
            idx_q  <= '0;
          end
        end
        StRow: begin
          buf_q[idx_q] <= row_y;
          idx_q        <= idx_q + 2'd1;
          if (idx_q == 2'd3) sat_q <= 1'b0;
        end
        StCol: begin
          for (int k = 0; k < 4; k++) residuals_q[{2'(k), idx_q}] <= col_res[k];
          sat_q <= sat_q | col_clip;
          idx_q <= idx_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle) && !reset;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign residuals = residuals_q;
  assign sat       = sat_q;

endmodule
